// File: rtl/sdr_cmd_datapath.sv
// SDRAM pin-level back end: registered command/address/data pins decoded from the
// init and command FSM states, APB address/data latches, read capture and the
// auto-refresh interval timer.

package sdr_parameters;
  localparam logic [3:0] i_NOP    = 4'd0;
  localparam logic [3:0] i_PRE    = 4'd1;
  localparam logic [3:0] i_tRP    = 4'd2;
  localparam logic [3:0] i_AR1    = 4'd3;
  localparam logic [3:0] i_tRFC1  = 4'd4;
  localparam logic [3:0] i_AR2    = 4'd5;
  localparam logic [3:0] i_tRFC2  = 4'd6;
  localparam logic [3:0] i_MRS    = 4'd7;
  localparam logic [3:0] i_tMRD   = 4'd8;
  localparam logic [3:0] i_ready  = 4'd9;

  localparam logic [3:0] c_idle   = 4'd0;
  localparam logic [3:0] c_tRCD   = 4'd1;
  localparam logic [3:0] c_cl     = 4'd2;
  localparam logic [3:0] c_rdata  = 4'd3;
  localparam logic [3:0] c_wdata  = 4'd4;
  localparam logic [3:0] c_tRFC   = 4'd5;
  localparam logic [3:0] c_tDAL   = 4'd6;
  localparam logic [3:0] c_ACTIVE = 4'd7;
  localparam logic [3:0] c_READA  = 4'd8;
  localparam logic [3:0] c_WRITEA = 4'd9;
  localparam logic [3:0] c_AR     = 4'd10;
endpackage

module sdr_cmd_datapath
  import sdr_parameters::*;
#(
  parameter int               BA_W     = 2,
  parameter int               ROW_W    = 13,
  parameter int               COL_W    = 9,
  parameter int               DATA_W   = 16,
  parameter logic [ROW_W-1:0] MODE_REG = 13'h020,
  parameter int               REF_INT  = 780
) (
  input  logic                        pclk,
  input  logic                        preset,
  input  logic [3:0]                  iState,
  input  logic [3:0]                  cState,
  input  logic [3:0]                  clkCNT,
  input  logic [BA_W+ROW_W+COL_W-1:0] paddr,
  input  logic [DATA_W-1:0]           pwdata,
  input  logic [DATA_W-1:0]           sdr_DQ_in,
  output logic                        sdr_CKE,
  output logic                        sdr_CSn,
  output logic                        sdr_RASn,
  output logic                        sdr_CASn,
  output logic                        sdr_WEn,
  output logic [BA_W-1:0]             sdr_BA,
  output logic [ROW_W-1:0]            sdr_A,
  output logic                        sdr_DQM,
  output logic [DATA_W-1:0]           sdr_DQ_out,
  output logic                        sdr_DQ_oe,
  output logic [DATA_W-1:0]           prdata,
  output logic                        prdata_vld,
  output logic                        ref_req,
  output logic                        ref_miss
);

  localparam int AW = BA_W + ROW_W + COL_W;
  localparam int TW = (REF_INT > 2) ? $clog2(REF_INT) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(REF_INT - 1);

  // {CSn,RASn,CASn,WEn}
  localparam logic [3:0] CMD_MRS    = 4'b0000;
  localparam logic [3:0] CMD_AREF   = 4'b0001;
  localparam logic [3:0] CMD_PRE    = 4'b0010;
  localparam logic [3:0] CMD_ACT    = 4'b0011;
  localparam logic [3:0] CMD_WRITEA = 4'b0100;
  localparam logic [3:0] CMD_READA  = 4'b0101;
  localparam logic [3:0] CMD_NOP    = 4'b0111;
  localparam logic [3:0] CMD_RST    = 4'b1111;

  logic              cke_q;
  logic [3:0]        cmd_q, cmd_d;
  logic [BA_W-1:0]   ba_q, ba_d;
  logic [ROW_W-1:0]  a_q, a_d;
  logic              dqm_q, dqm_d;
  logic              oe_q, oe_d;
  logic [DATA_W-1:0] dq_q, dq_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              vld_q, vld_d;
  logic [BA_W-1:0]   bank_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [DATA_W-1:0] wdata_q;
  logic [TW-1:0]     timer_q, timer_d;
  logic              req_q, req_d;
  logic              miss_q, miss_d;
  logic [ROW_W-1:0]  col_addr;
  logic              timer_run, expire, ar_seen;

  // Column address with auto-precharge bit forced on.
  always_comb begin
    col_addr = '0;
    col_addr[COL_W-1:0] = col_q;
    col_addr[10] = 1'b1;
  end

  // Command/address decode; undefined or idle states become NOP holding A/BA.
  always_comb begin
    cmd_d = CMD_NOP;
    ba_d  = ba_q;
    a_d   = a_q;
    case (iState)
      i_PRE: begin
        cmd_d   = CMD_PRE;
        a_d     = '0;
        a_d[10] = 1'b1;
      end
      i_AR1, i_AR2: cmd_d = CMD_AREF;
      i_MRS: begin
        cmd_d = CMD_MRS;
        a_d   = MODE_REG;
        ba_d  = '0;
      end
      i_ready: begin
        case (cState)
          c_ACTIVE: begin
            cmd_d = CMD_ACT;
            a_d   = row_q;
            ba_d  = bank_q;
          end
          c_READA: begin
            cmd_d = CMD_READA;
            a_d   = col_addr;
            ba_d  = bank_q;
          end
          c_WRITEA: begin
            cmd_d = CMD_WRITEA;
            a_d   = col_addr;
            ba_d  = bank_q;
          end
          c_AR:    cmd_d = CMD_AREF;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // DQ drive, data mask and read capture.
  always_comb begin
    dqm_d = 1'b1;
    oe_d  = 1'b0;
    dq_d  = dq_q;
    case (cState)
      c_WRITEA: begin
        oe_d  = 1'b1;
        dqm_d = 1'b0;
        dq_d  = wdata_q;
      end
      c_wdata:                 oe_d  = 1'b1;
      c_READA, c_cl, c_rdata:  dqm_d = 1'b0;
      default: ;
    endcase
    vld_d    = (cState == c_rdata) && (clkCNT == 4'd0);
    prdata_d = vld_d ? sdr_DQ_in : prdata_q;
  end

  // Refresh interval timer; a fresh expiry outranks the c_AR acknowledge.
  always_comb begin
    timer_run = (iState == i_ready);
    expire    = timer_run && (timer_q == '0);
    ar_seen   = (cState == c_AR);
    timer_d   = timer_q;
    if (timer_run) timer_d = expire ? RELOAD : timer_q - 1'b1;
    req_d  = expire ? 1'b1 : (ar_seen ? 1'b0 : req_q);
    miss_d = miss_q | (expire & req_q & ~ar_seen);
  end

  // Pin registers.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cke_q    <= 1'b0;
      cmd_q    <= CMD_RST;
      ba_q     <= '0;
      a_q      <= '0;
      dqm_q    <= 1'b1;
      oe_q     <= 1'b0;
      dq_q     <= '0;
      prdata_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      cke_q    <= 1'b1;
      cmd_q    <= cmd_d;
      ba_q     <= ba_d;
      a_q      <= a_d;
      dqm_q    <= dqm_d;
      oe_q     <= oe_d;
      dq_q     <= dq_d;
      prdata_q <= prdata_d;
      vld_q    <= vld_d;
    end
  end

  // Address/write-data latches track the APB bus only while idle.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      bank_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      wdata_q <= '0;
    end else if (cState == c_idle) begin
      bank_q  <= paddr[AW-1 -: BA_W];
      row_q   <= paddr[COL_W +: ROW_W];
      col_q   <= paddr[COL_W-1:0];
      wdata_q <= pwdata;
    end
  end

  // Refresh timer and request flags.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      timer_q <= RELOAD;
      req_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      req_q   <= req_d;
      miss_q  <= miss_d;
    end
  end

  assign sdr_CKE    = cke_q;
  assign sdr_CSn    = cmd_q[3];
  assign sdr_RASn   = cmd_q[2];
  assign sdr_CASn   = cmd_q[1];
  assign sdr_WEn    = cmd_q[0];
  assign sdr_BA     = ba_q;
  assign sdr_A      = a_q;
  assign sdr_DQM    = dqm_q;
  assign sdr_DQ_out = dq_q;
  assign sdr_DQ_oe  = oe_q;
  assign prdata     = prdata_q;
  assign prdata_vld = vld_q;
  assign ref_req    = req_q;
  assign ref_miss   = miss_q;

endmodule

// File: tb/tb_sdr_cmd_datapath.sv
// Bench for sdr_cmd_datapath: behavioural pin model plus directed scenario checks.
module tb_sdr_cmd_datapath;
  import sdr_parameters::*;

  localparam int REF = 20;
  localparam logic [3:0] NOP = 4'b0111, PRE = 4'b0010, AREF = 4'b0001, MRS = 4'b0000;
  localparam logic [3:0] ACT = 4'b0011, RDA = 4'b0101, WRA = 4'b0100;
  localparam logic [56:0] RESET_PINS = {1'b0, 4'hF, 2'b0, 13'h0, 1'b1, 1'b0, 16'h0, 16'h0, 3'b000};

  logic        pclk = 1'b0;
  logic        preset;
  logic [3:0]  iState, cState, clkCNT;
  logic [23:0] paddr;
  logic [15:0] pwdata, dq_in;

  logic        sdr_CKE, sdr_CSn, sdr_RASn, sdr_CASn, sdr_WEn, sdr_DQM, sdr_DQ_oe;
  logic [1:0]  sdr_BA;
  logic [12:0] sdr_A;
  logic [15:0] sdr_DQ_out, prdata;
  logic        prdata_vld, ref_req, ref_miss;

  int total = 0;
  int bad   = 0;

  sdr_cmd_datapath #(.REF_INT(REF)) dut (
    .pclk(pclk), .preset(preset), .iState(iState), .cState(cState), .clkCNT(clkCNT),
    .paddr(paddr), .pwdata(pwdata), .sdr_DQ_in(dq_in),
    .sdr_CKE(sdr_CKE), .sdr_CSn(sdr_CSn), .sdr_RASn(sdr_RASn), .sdr_CASn(sdr_CASn),
    .sdr_WEn(sdr_WEn), .sdr_BA(sdr_BA), .sdr_A(sdr_A), .sdr_DQM(sdr_DQM),
    .sdr_DQ_out(sdr_DQ_out), .sdr_DQ_oe(sdr_DQ_oe), .prdata(prdata),
    .prdata_vld(prdata_vld), .ref_req(ref_req), .ref_miss(ref_miss)
  );

  always #5 pclk = ~pclk;

  // Reference model: what the pins must show after the next rising edge.
  logic        m_cke, m_dqm, m_oe, m_vld, m_req, m_miss;
  logic [3:0]  m_cmd;
  logic [1:0]  m_ba, l_bank;
  logic [12:0] m_a, l_row;
  logic [8:0]  l_col;
  logic [15:0] m_dq, m_prd, l_wd;
  int          ready_cycles;

  wire [56:0] pins = {sdr_CKE, sdr_CSn, sdr_RASn, sdr_CASn, sdr_WEn, sdr_BA, sdr_A,
                      sdr_DQM, sdr_DQ_oe, sdr_DQ_out, prdata, prdata_vld, ref_req, ref_miss};
  wire [56:0] want = {m_cke, m_cmd, m_ba, m_a, m_dqm, m_oe, m_dq, m_prd, m_vld, m_req, m_miss};
  wire [3:0]  cmd_pins = {sdr_CSn, sdr_RASn, sdr_CASn, sdr_WEn};

  task automatic model_reset();
    m_cke = 0; m_cmd = 4'hF; m_ba = 0; m_a = 0; m_dqm = 1; m_oe = 0; m_dq = 0;
    m_prd = 0; m_vld = 0; m_req = 0; m_miss = 0;
    l_bank = 0; l_row = 0; l_col = 0; l_wd = 0; ready_cycles = 0;
  endtask

  // Advance the model for the current inputs, then one clock; returns at the falling edge.
  task automatic tick();
    logic due;
    m_cke = 1'b1;
    m_cmd = NOP;
    if (iState == i_PRE) begin m_cmd = PRE; m_a = 13'h400; end
    else if (iState == i_AR1 || iState == i_AR2) m_cmd = AREF;
    else if (iState == i_MRS) begin m_cmd = MRS; m_a = 13'h020; m_ba = 0; end
    else if (iState == i_ready) begin
      if (cState == c_ACTIVE) begin m_cmd = ACT; m_a = l_row; m_ba = l_bank; end
      else if (cState == c_READA)  begin m_cmd = RDA; m_a = 13'h400 | {4'b0, l_col}; m_ba = l_bank; end
      else if (cState == c_WRITEA) begin m_cmd = WRA; m_a = 13'h400 | {4'b0, l_col}; m_ba = l_bank; end
      else if (cState == c_AR) m_cmd = AREF;
    end
    m_oe  = (cState == c_WRITEA) || (cState == c_wdata);
    m_dqm = !((cState == c_WRITEA) || (cState == c_READA) || (cState == c_cl) || (cState == c_rdata));
    if (cState == c_WRITEA) m_dq = l_wd;
    m_vld = (cState == c_rdata) && (clkCNT == 0);
    if (m_vld) m_prd = dq_in;
    due = 1'b0;
    if (iState == i_ready) begin
      ready_cycles++;
      due = (ready_cycles % REF) == 0;
    end
    if (due && m_req && cState != c_AR) m_miss = 1'b1;
    if (due) m_req = 1'b1;
    else if (cState == c_AR) m_req = 1'b0;
    if (cState == c_idle) begin
      l_bank = paddr[23:22]; l_row = paddr[21:9]; l_col = paddr[8:0]; l_wd = pwdata;
    end
    @(posedge pclk);
    @(negedge pclk);
  endtask

  task automatic drive(input logic [3:0] i, input logic [3:0] c, input logic [3:0] k);
    iState = i; cState = c; clkCNT = k;
    paddr = 24'($urandom); pwdata = 16'($urandom); dq_in = 16'($urandom);
  endtask

  task automatic hard_reset();
    @(negedge pclk);
    preset = 1'b1;
    model_reset();
    #1;
    total++;
    if (pins !== RESET_PINS) begin
      bad++; $display("FAIL reset_pins: got %h want %h", pins, RESET_PINS);
    end
    @(negedge pclk);
    preset = 1'b0;
  endtask

  task automatic test_reset();
    preset = 1'b0;
    drive(i_NOP, c_idle, 0);
    #1 preset = 1'b1;
    model_reset();
    @(negedge pclk);
    total++;
    if (pins !== RESET_PINS) begin
      bad++; $display("FAIL reset_state: got %h want %h", pins, RESET_PINS);
    end
    preset = 1'b0;
    drive(i_NOP, c_idle, 0);
    tick();
    total++;
    if (sdr_CKE !== 1'b1 || cmd_pins !== NOP) begin
      bad++; $display("FAIL cke_after_release: got cke=%b cmd=%b want cke=1 cmd=0111", sdr_CKE, cmd_pins);
    end
  endtask

  task automatic test_init();
    logic [3:0] seq [11] = '{i_NOP, i_PRE, i_tRP, i_AR1, i_tRFC1, i_tRFC1, i_AR2, i_tRFC2, i_MRS, i_tMRD, i_ready};
    logic [3:0] cmd [11] = '{NOP, PRE, NOP, AREF, NOP, NOP, AREF, NOP, MRS, NOP, NOP};
    for (int n = 0; n < 11; n++) begin
      drive(seq[n], c_idle, 4'(n));
      tick();
      total++;
      if (pins !== want) begin
        bad++; $display("FAIL init_model step %0d: got %h want %h", n, pins, want);
      end
      total++;
      if (cmd_pins !== cmd[n] || (seq[n] == i_PRE && sdr_A[10] !== 1'b1) ||
          (seq[n] == i_MRS && (sdr_A !== 13'h020 || sdr_BA !== 2'd0))) begin
        bad++; $display("FAIL init_cmd step %0d: got cmd=%b A=%h BA=%0d want cmd=%b", n, cmd_pins, sdr_A, sdr_BA, cmd[n]);
      end
    end
  endtask

  task automatic test_write(input logic stop_in_wdata);
    logic [3:0] seq [7] = '{c_idle, c_ACTIVE, c_tRCD, c_WRITEA, c_wdata, c_tDAL, c_idle};
    for (int n = 0; n < 7; n++) begin
      drive(i_ready, seq[n], 0);
      if (n == 0) begin paddr = {2'd1, 13'h0ABC, 9'h055}; pwdata = 16'hBEEF; end
      tick();
      total++;
      if (pins !== want) begin
        bad++; $display("FAIL write_model step %0d: got %h want %h", n, pins, want);
      end
      if (seq[n] == c_ACTIVE) begin
        total++;
        if (cmd_pins !== ACT || sdr_BA !== 2'd1 || sdr_A !== 13'h0ABC) begin
          bad++; $display("FAIL write_act: got cmd=%b BA=%0d A=%h want 0011/1/0ABC", cmd_pins, sdr_BA, sdr_A);
        end
      end
      if (seq[n] == c_WRITEA) begin
        total++;
        if (cmd_pins !== WRA || sdr_A !== 13'h0455 || sdr_DQ_out !== 16'hBEEF || sdr_DQ_oe !== 1'b1 || sdr_DQM !== 1'b0) begin
          bad++; $display("FAIL write_cmd: got cmd=%b A=%h DQ=%h oe=%b dqm=%b want 0100/0455/BEEF/1/0",
                          cmd_pins, sdr_A, sdr_DQ_out, sdr_DQ_oe, sdr_DQM);
        end
      end
      if (seq[n] == c_wdata) begin
        total++;
        if (sdr_DQ_oe !== 1'b1 || sdr_DQM !== 1'b1) begin
          bad++; $display("FAIL write_mask: got oe=%b dqm=%b want 1/1", sdr_DQ_oe, sdr_DQM);
        end
        if (stop_in_wdata) break;
      end
    end
  endtask

  task automatic test_read();
    logic [3:0] seq [8] = '{c_idle, c_ACTIVE, c_tRCD, c_READA, c_cl, c_rdata, c_rdata, c_idle};
    logic [3:0] cnt [8] = '{0, 0, 0, 0, 1, 0, 3, 0};
    for (int n = 0; n < 8; n++) begin
      drive(i_ready, seq[n], cnt[n]);
      if (n == 0) paddr = {2'd1, 13'h0ABC, 9'h055};
      if (n == 5) dq_in = 16'h1234;
      if (n == 6) dq_in = 16'h5555;
      tick();
      total++;
      if (pins !== want) begin
        bad++; $display("FAIL read_model step %0d: got %h want %h", n, pins, want);
      end
      if (n == 3) begin
        total++;
        if (cmd_pins !== RDA || sdr_A !== 13'h0455 || sdr_BA !== 2'd1 || sdr_DQM !== 1'b0) begin
          bad++; $display("FAIL read_cmd: got cmd=%b A=%h BA=%0d dqm=%b want 0101/0455/1/0", cmd_pins, sdr_A, sdr_BA, sdr_DQM);
        end
      end
      if (n >= 5) begin
        total++;
        if (prdata !== 16'h1234 || prdata_vld !== (n == 5)) begin
          bad++; $display("FAIL read_capture step %0d: got prdata=%h vld=%b want 1234/%b", n, prdata, prdata_vld, n == 5);
        end
      end
    end
  endtask

  task automatic test_refresh_miss();
    hard_reset();
    for (int k = 1; k <= 41; k++) begin
      drive(i_ready, c_idle, 0);
      tick();
      total++;
      if (pins !== want || ref_req !== (k >= 20) || ref_miss !== (k >= 40)) begin
        bad++; $display("FAIL refresh_miss cycle %0d: got req=%b miss=%b pins=%h want req=%b miss=%b pins=%h",
                        k, ref_req, ref_miss, pins, k >= 20, k >= 40, want);
      end
    end
  endtask

  task automatic test_ar_collision();
    hard_reset();
    for (int k = 1; k <= 42; k++) begin
      drive(i_ready, (k == 40 || k == 41) ? c_AR : c_idle, 0);
      tick();
      total++;
      if (pins !== want || ref_req !== (k >= 20 && k <= 40) || ref_miss !== 1'b0) begin
        bad++; $display("FAIL ar_collision cycle %0d: got req=%b miss=%b want req=%b miss=0",
                        k, ref_req, ref_miss, k >= 20 && k <= 40);
      end
    end
  endtask

  task automatic test_preset_mid();
    hard_reset();
    test_init();
    test_write(1'b1);
    drive(i_ready, c_wdata, 0);
    #2 preset = 1'b1;
    model_reset();
    #1;
    total++;
    if (sdr_DQ_oe !== 1'b0 || sdr_CSn !== 1'b1 || sdr_CKE !== 1'b0 || pins !== RESET_PINS) begin
      bad++; $display("FAIL preset_mid: got oe=%b csn=%b cke=%b pins=%h want 0/1/0 %h",
                      sdr_DQ_oe, sdr_CSn, sdr_CKE, pins, RESET_PINS);
    end
    @(negedge pclk);
    preset = 1'b0;
    test_init();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(63) == 0) begin
        hard_reset();
      end else begin
        drive(($urandom_range(1) == 0) ? i_ready : 4'($urandom_range(15)),
              4'($urandom_range(15)), 4'($urandom_range(3)));
        tick();
        total++;
        if (pins !== want) begin
          bad++; $display("FAIL random cycle %0d: got %h want %h (i=%0d c=%0d k=%0d)",
                          n, pins, want, iState, cState, clkCNT);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_write(1'b0);
    test_read();
    test_refresh_miss();
    test_ar_collision();
    test_preset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
